// File: rtl/ahbl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ahbl_pkg
// Purpose : Shared AHB-Lite encodings, arbiter FSM state type and limits for
//           the ahbl_master_arbiter block and its round-robin picker.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package ahbl_pkg;

    localparam int MAX_REQ = 4;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } arb_state_t;

    // Sizes above a word are not supported on a 32-bit bus; saturate to word.
    function automatic logic [2:0] clamp_size(input logic [2:0] size);
        return (size > HSIZE_WORD) ? HSIZE_WORD : size;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// ============================================================================
// Module  : rr_picker
// Purpose : Combinational round-robin selector. Scans the request vector
//           starting at index ptr and wrapping modulo NUM_REQ; the first
//           active request wins.
// Ports   : req   in  NUM_REQ  request vector
//           ptr   in  2        highest-priority index (must be < NUM_REQ)
//           gnt   out NUM_REQ  one-hot grant (all zero when no request)
//           idx   out 2        index of the granted request
//           found out 1        at least one request is active
// Revision: 1.0 - initial release
// ============================================================================
module rr_picker
    import ahbl_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [1:0]         idx,
    output logic               found
);

    // Work on 4-bit copies so a 2-bit index always addresses exactly.
    logic [MAX_REQ-1:0] req_ext;
    logic [MAX_REQ-1:0] gnt_ext;
    logic [1:0]         cand;

    always_comb begin
        req_ext                = '0;
        req_ext[NUM_REQ-1:0]   = req;
    end

    always_comb begin
        gnt_ext = '0;
        idx     = '0;
        found   = 1'b0;
        cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = 2'((int'(ptr) + k) % NUM_REQ);
            if (!found && req_ext[cand]) begin
                found         = 1'b1;
                idx           = cand;
                gnt_ext[cand] = 1'b1;
            end
        end
    end

    assign gnt = gnt_ext[NUM_REQ-1:0];

endmodule
`default_nettype wire

// File: rtl/ahbl_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : ahbl_master_arbiter
// Purpose : Round-robin arbiter sharing one AHB-Lite master port between up
//           to four request/response clients. Each accepted command becomes a
//           single NONSEQ transfer; the data-phase result is returned to the
//           granted client as a one-cycle RSP_VALID pulse.
// Config  : AHBL_ARB_LOCK_EN - adds REQ_LOCK; a locked command drives
//           HMASTLOCK in its address phase and pins arbitration to that
//           client until it issues an unlocked command.
// Ports   : HCLK/HRESET        clock, synchronous active-high reset
//           REQ_* / RSP_*      client command and response channels
//           H* outputs         AHB-Lite master address/data phase (registered)
//           HRDATA/HREADY/HRESP slave returns
// Revision: 1.0 - initial release
// ============================================================================
module ahbl_master_arbiter
    import ahbl_pkg::*;
#(
    parameter int         NUM_REQ   = 2,
    parameter logic [3:0] HPROT_VAL = 4'b0011
) (
    input  logic                    HCLK,
    input  logic                    HRESET,
    input  logic [NUM_REQ-1:0]      REQ_VALID,
    output logic [NUM_REQ-1:0]      REQ_READY,
    input  logic [NUM_REQ-1:0]      REQ_WRITE,
    input  logic [32*NUM_REQ-1:0]   REQ_ADDR,
    input  logic [32*NUM_REQ-1:0]   REQ_WDATA,
    input  logic [3*NUM_REQ-1:0]    REQ_SIZE,
`ifdef AHBL_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]      REQ_LOCK,
`endif
    output logic [NUM_REQ-1:0]      RSP_VALID,
    output logic [31:0]             RSP_RDATA,
    output logic                    RSP_ERR,
    output logic [31:0]             HADDR,
    output logic                    HWRITE,
    output logic [2:0]              HSIZE,
    output logic [2:0]              HBURST,
    output logic [3:0]              HPROT,
    output logic [1:0]              HTRANS,
    output logic                    HMASTLOCK,
    output logic [31:0]             HWDATA,
    input  logic [31:0]             HRDATA,
    input  logic                    HREADY,
    input  logic                    HRESP
);

    localparam logic [1:0] LAST_IDX = 2'(NUM_REQ - 1);

    arb_state_t         state, state_nxt;
    logic [1:0]         ptr;
    logic [1:0]         next_ptr;
    logic [NUM_REQ-1:0] owner;       // one-hot client of the transfer in flight
    logic [NUM_REQ-1:0] pick_req;
    logic [NUM_REQ-1:0] gnt;
    logic [1:0]         win_idx;
    logic               found;

    // Per-client fields unpacked to 4-entry arrays so a 2-bit index is exact.
    logic [31:0]        addr_arr  [MAX_REQ];
    logic [31:0]        wdata_arr [MAX_REQ];
    logic [2:0]         size_arr  [MAX_REQ];
    logic [MAX_REQ-1:0] write_ext;

    generate
        for (genvar g = 0; g < MAX_REQ; g++) begin : g_unpack
            if (g < NUM_REQ) begin : g_used
                assign addr_arr[g]  = REQ_ADDR[32*g +: 32];
                assign wdata_arr[g] = REQ_WDATA[32*g +: 32];
                assign size_arr[g]  = REQ_SIZE[3*g +: 3];
                assign write_ext[g] = REQ_WRITE[g];
            end else begin : g_unused
                assign addr_arr[g]  = '0;
                assign wdata_arr[g] = '0;
                assign size_arr[g]  = '0;
                assign write_ext[g] = 1'b0;
            end
        end
    endgenerate

`ifdef AHBL_ARB_LOCK_EN
    logic               lock_held;
    logic [NUM_REQ-1:0] ptr_oh;
    logic [MAX_REQ-1:0] lock_ext;

    generate
        for (genvar g = 0; g < MAX_REQ; g++) begin : g_lock
            if (g < NUM_REQ) begin : g_used
                assign lock_ext[g] = REQ_LOCK[g];
                assign ptr_oh[g]   = (ptr == 2'(g));
            end else begin : g_unused
                assign lock_ext[g] = 1'b0;
            end
        end
    endgenerate

    // While a lock is held only the pinned client is visible to the picker.
    assign pick_req = lock_held ? (REQ_VALID & ptr_oh) : REQ_VALID;
`else
    assign pick_req  = REQ_VALID;
    assign HMASTLOCK = 1'b0;
`endif

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req   (pick_req),
        .ptr   (ptr),
        .gnt   (gnt),
        .idx   (win_idx),
        .found (found)
    );

    assign next_ptr = (win_idx == LAST_IDX) ? 2'd0 : win_idx + 2'd1;
    assign HBURST   = HBURST_SINGLE;
    assign HPROT    = HPROT_VAL;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        REQ_READY = '0;
        case (state)
            ST_IDLE: begin
                if (found) begin
                    state_nxt = ST_ADDR;
                end
                // Masked in reset so no command is acknowledged and then lost.
                if (!HRESET) begin
                    REQ_READY = gnt;
                end
            end
            ST_ADDR: if (HREADY) state_nxt = ST_DATA;
            ST_DATA: if (HREADY) state_nxt = ST_RESP;
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            HADDR     <= '0;
            HWRITE    <= 1'b0;
            HSIZE     <= HSIZE_BYTE;
            HWDATA    <= '0;
            HTRANS    <= HTRANS_IDLE;
            RSP_VALID <= '0;
            RSP_RDATA <= '0;
            RSP_ERR   <= 1'b0;
            ptr       <= '0;
            owner     <= '0;
`ifdef AHBL_ARB_LOCK_EN
            lock_held <= 1'b0;
            HMASTLOCK <= 1'b0;
`endif
        end else begin
            RSP_VALID <= '0;
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        HADDR  <= addr_arr[win_idx];
                        HWRITE <= write_ext[win_idx];
                        HSIZE  <= clamp_size(size_arr[win_idx]);
                        HWDATA <= wdata_arr[win_idx];
                        HTRANS <= HTRANS_NONSEQ;
                        owner  <= gnt;
`ifdef AHBL_ARB_LOCK_EN
                        if (lock_ext[win_idx]) begin
                            lock_held <= 1'b1;
                            ptr       <= win_idx;
                            HMASTLOCK <= 1'b1;
                        end else begin
                            lock_held <= 1'b0;
                            ptr       <= next_ptr;
                            HMASTLOCK <= 1'b0;
                        end
`else
                        ptr    <= next_ptr;
`endif
                    end
                end
                ST_ADDR: begin
                    if (HREADY) begin
                        HTRANS    <= HTRANS_IDLE;
`ifdef AHBL_ARB_LOCK_EN
                        HMASTLOCK <= 1'b0;
`endif
                    end
                end
                ST_DATA: begin
                    // HRESP with HREADY low is the first error cycle: just wait.
                    if (HREADY) begin
                        RSP_ERR   <= HRESP;
                        RSP_RDATA <= (HRESP || HWRITE) ? 32'd0 : HRDATA;
                        RSP_VALID <= owner;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ahbl_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_ahbl_master_arbiter
// Purpose : Self-checking bench for ahbl_master_arbiter with a transfer-level
//           reference model, directed scenarios and randomized traffic.
//           Lock scenarios compile in when AHBL_ARB_LOCK_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ahbl_master_arbiter;

    localparam int N = 2;

    logic               HCLK = 1'b0;
    logic               HRESET;
    logic [N-1:0]       REQ_VALID, REQ_READY, REQ_WRITE, RSP_VALID;
    logic [32*N-1:0]    REQ_ADDR, REQ_WDATA;
    logic [3*N-1:0]     REQ_SIZE;
`ifdef AHBL_ARB_LOCK_EN
    logic [N-1:0]       REQ_LOCK;
`endif
    logic [31:0]        RSP_RDATA, HADDR, HWDATA, HRDATA;
    logic               RSP_ERR, HWRITE, HMASTLOCK, HREADY, HRESP;
    logic [2:0]         HSIZE, HBURST;
    logic [3:0]         HPROT;
    logic [1:0]         HTRANS;

    always #5 HCLK = ~HCLK;

    ahbl_master_arbiter #(.NUM_REQ(N), .HPROT_VAL(4'b0011)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WRITE(REQ_WRITE),
        .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .REQ_SIZE(REQ_SIZE),
`ifdef AHBL_ARB_LOCK_EN
        .REQ_LOCK(REQ_LOCK),
`endif
        .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
        .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
        .HPROT(HPROT), .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    // ---------------------------------------------------- reference model
    // phase: 0 no transfer, 1 address phase, 2 data phase, 3 response cycle
    int          m_phase, m_ptr, m_cli;
    bit          m_lock_held, m_cur_lock, m_hwrite, m_exp_err;
    logic [31:0] m_haddr, m_hwdata, m_exp_rdata;
    logic [2:0]  m_hsize;

    function automatic void model_reset();
        m_phase = 0; m_ptr = 0; m_cli = 0; m_lock_held = 0; m_cur_lock = 0;
        m_hwrite = 0; m_haddr = 0; m_hwdata = 0; m_hsize = 0;
        m_exp_err = 0; m_exp_rdata = 0;
    endfunction

    function automatic int m_winner();
        int c;
        for (int k = 0; k < N; k++) begin
            c = (m_ptr + k) % N;
            if (REQ_VALID[c] && (!m_lock_held || c == m_ptr)) return c;
        end
        return -1;
    endfunction

    function automatic bit cmd_lock(input int c);
`ifdef AHBL_ARB_LOCK_EN
        return REQ_LOCK[c];
`else
        return 1'b0;
`endif
    endfunction

    // Compare all outputs for the current cycle, then advance the model by
    // the inputs that the coming edge will sample.
    task automatic compare_step();
        int w;
        logic [N-1:0] exp_ready, exp_rsp;
        logic [2:0] sz;
        w = m_winner();
        exp_ready = '0;
        if (m_phase == 0 && !HRESET && w >= 0) exp_ready[w] = 1'b1;
        exp_rsp = '0;
        if (m_phase == 3) exp_rsp[m_cli] = 1'b1;
        chk("req_ready", REQ_READY, exp_ready);
        chk("htrans",    HTRANS, (m_phase == 1) ? 2'b10 : 2'b00);
        chk("haddr",     HADDR, m_haddr);
        chk("hwrite",    HWRITE, m_hwrite);
        chk("hsize",     HSIZE, m_hsize);
        chk("hwdata",    HWDATA, m_hwdata);
        chk("hburst",    HBURST, 3'b000);
        chk("hprot",     HPROT, 4'b0011);
        chk("hmastlock", HMASTLOCK, (m_phase == 1) && m_cur_lock);
        chk("rsp_valid", RSP_VALID, exp_rsp);
        if (m_phase == 3) begin
            chk("rsp_err", RSP_ERR, m_exp_err);
            if (!m_exp_err) chk("rsp_rdata", RSP_RDATA, m_exp_rdata);
        end
        if (HRESET) begin
            model_reset();
        end else begin
            case (m_phase)
                0: if (w >= 0) begin
                    m_cli      = w;
                    m_haddr    = REQ_ADDR[32*w +: 32];
                    m_hwdata   = REQ_WDATA[32*w +: 32];
                    m_hwrite   = REQ_WRITE[w];
                    sz         = REQ_SIZE[3*w +: 3];
                    m_hsize    = (sz > 3'd2) ? 3'd2 : sz;
                    m_cur_lock = cmd_lock(w);
                    m_lock_held = m_cur_lock;
                    m_ptr      = m_cur_lock ? w : (w + 1) % N;
                    m_phase    = 1;
                end
                1: if (HREADY) m_phase = 2;
                2: if (HREADY) begin
                    m_exp_err   = HRESP;
                    m_exp_rdata = (HRESP || m_hwrite) ? 32'd0 : HRDATA;
                    m_phase     = 3;
                end
                default: m_phase = 0;
            endcase
        end
    endtask

    task automatic tick();
        @(negedge HCLK);
        compare_step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic set_cmd(input int c, input bit wr, input logic [31:0] a,
                           input logic [31:0] d, input logic [2:0] s);
        REQ_WRITE[c]         = wr;
        REQ_ADDR[32*c +: 32]  = a;
        REQ_WDATA[32*c +: 32] = d;
        REQ_SIZE[3*c +: 3]    = s;
    endtask

    task automatic wait_idle();
        int b;
        b = 0;
        HREADY = 1'b1; HRESP = 1'b0;
        while (m_phase != 0 && b < 60) begin
            tick();
            b++;
        end
        checks++;
        if (m_phase != 0) begin
            failures++;
            $display("FAIL wait_idle_timeout at %0t: actual=phase%0d required=phase0", $time, m_phase);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int          acc_cyc [4];
    logic [N-1:0] acc_gnt [4];
    int          nacc;
    bit          err_pending;

    initial begin
        HRESET = 1'b1; REQ_VALID = '0; REQ_WRITE = '0; REQ_ADDR = '0;
        REQ_WDATA = '0; REQ_SIZE = '0; HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
`ifdef AHBL_ARB_LOCK_EN
        REQ_LOCK = '0;
`endif
        repeat (3) @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        model_reset();

        // Reset state
        chk("rst_htrans", HTRANS, 2'b00);
        chk("rst_haddr", HADDR, 32'd0);
        chk("rst_hwdata", HWDATA, 32'd0);
        chk("rst_hprot", HPROT, 4'b0011);
        chk("rst_rsp_valid", RSP_VALID, 2'b00);
        chk("rst_hmastlock", HMASTLOCK, 1'b0);

        // Client 0 write, zero waits
        set_cmd(0, 1'b1, 32'h0000_0010, 32'hA5A5_0001, 3'd2);
        REQ_VALID = 2'b01; #1;
        chk("t1_ready", REQ_READY, 2'b01);
        tick(); REQ_VALID = '0;
        chk("t1_nonseq", HTRANS, 2'b10);
        chk("t1_haddr", HADDR, 32'h10);
        tick();
        chk("t1_htrans_idle", HTRANS, 2'b00);
        chk("t1_hwdata", HWDATA, 32'hA5A5_0001);
        tick();
        chk("t1_rsp_valid", RSP_VALID, 2'b01);
        chk("t1_rsp_err", RSP_ERR, 1'b0);
        tick();
        chk("t1_rsp_done", RSP_VALID, 2'b00);

        // Client 1 read with three data-phase wait states
        set_cmd(1, 1'b0, 32'h0000_0020, 32'h0, 3'd2);
        REQ_VALID = 2'b10; #1;
        chk("t2_ready", REQ_READY, 2'b10);
        tick(); REQ_VALID = '0;
        tick(); HREADY = 1'b0;
        tick();
        tick();
        tick(); HREADY = 1'b1; HRDATA = 32'h1234_5678;
        chk("t2_no_early_rsp", RSP_VALID, 2'b00);
        tick(); HRDATA = 32'h0;
        chk("t2_rsp_valid", RSP_VALID, 2'b10);
        chk("t2_rsp_rdata", RSP_RDATA, 32'h1234_5678);
        tick();

        // Both clients request continuously: alternate grants 4 cycles apart
        set_cmd(0, 1'b1, 32'h100, 32'h11, 3'd2);
        set_cmd(1, 1'b1, 32'h200, 32'h22, 3'd2);
        REQ_VALID = 2'b11; nacc = 0;
        for (int i = 0; i < 40 && nacc < 4; i++) begin
            #1;
            if (REQ_READY != '0) begin
                acc_cyc[nacc] = i;
                acc_gnt[nacc] = REQ_READY;
                nacc++;
            end
            tick();
        end
        REQ_VALID = '0;
        chk("t3_accept_count", nacc, 4);
        for (int i = 0; i < nacc; i++) begin
            chk("t3_grant", acc_gnt[i], (i % 2 == 0) ? 2'b01 : 2'b10);
            if (i > 0) chk("t3_spacing", acc_cyc[i] - acc_cyc[i-1], 4);
        end
        wait_idle();

        // Two-cycle slave error on a read
        set_cmd(0, 1'b0, 32'h30, 32'h0, 3'd1);
        REQ_VALID = 2'b01; #1;
        chk("t4_ready", REQ_READY, 2'b01);
        tick(); REQ_VALID = '0;
        tick(); HRESP = 1'b1; HREADY = 1'b0;
        tick(); HRESP = 1'b1; HREADY = 1'b1;
        chk("t4_wait_no_rsp", RSP_VALID, 2'b00);
        tick(); HRESP = 1'b0;
        chk("t4_rsp_valid", RSP_VALID, 2'b01);
        chk("t4_rsp_err", RSP_ERR, 1'b1);
        tick();
        chk("t4_htrans_idle", HTRANS, 2'b00);
        chk("t4_single_rsp", RSP_VALID, 2'b00);

        // Reset during a data-phase wait state
        set_cmd(0, 1'b0, 32'h40, 32'h0, 3'd2);
        REQ_VALID = 2'b01; #1;
        tick(); REQ_VALID = '0;
        tick(); HREADY = 1'b0; HRESET = 1'b1;
        tick(); HRESET = 1'b0; HREADY = 1'b1;
        chk("t5_htrans_idle", HTRANS, 2'b00);
        chk("t5_no_rsp", RSP_VALID, 2'b00);
        REQ_VALID = 2'b11; #1;
        chk("t5_grant_client0", REQ_READY, 2'b01);
        tick(); REQ_VALID = '0;
        chk("t5_no_rsp_late", RSP_VALID, 2'b00);
        wait_idle();

`ifdef AHBL_ARB_LOCK_EN
        // Locked then unlocked command from client 1 while client 0 waits
        set_cmd(0, 1'b1, 32'h500, 32'h55, 3'd2);
        set_cmd(1, 1'b1, 32'h600, 32'h66, 3'd2);
        REQ_LOCK = 2'b10; REQ_VALID = 2'b11; #1;
        chk("lk_first_c1", REQ_READY, 2'b10);
        tick(); REQ_LOCK = 2'b00;
        set_cmd(1, 1'b1, 32'h610, 32'h67, 3'd2);
        chk("lk_mastlock_on", HMASTLOCK, 1'b1);
        wait_idle(); #1;
        chk("lk_second_c1", REQ_READY, 2'b10);
        tick();
        chk("lk_mastlock_off", HMASTLOCK, 1'b0);
        wait_idle(); #1;
        chk("lk_third_c0", REQ_READY, 2'b01);
        tick(); REQ_VALID = '0;
        wait_idle();
`endif

        // Randomized traffic
        err_pending = 1'b0;
        for (int i = 0; i < 800; i++) begin
            for (int c = 0; c < N; c++) begin
                REQ_VALID[c] = ($urandom % 2) == 0;
                set_cmd(c, $urandom % 2, $urandom, $urandom, 3'($urandom % 8));
`ifdef AHBL_ARB_LOCK_EN
                REQ_LOCK[c] = ($urandom % 4) == 0;
`endif
            end
            HRDATA = $urandom;
            HRESET = ($urandom % 100) == 0;
            if (m_phase == 2 && err_pending) begin
                HRESP = 1'b1; HREADY = 1'b1; err_pending = 1'b0;
            end else if (m_phase == 2 && ($urandom % 100) < 15) begin
                HRESP = 1'b1; HREADY = 1'b0; err_pending = 1'b1;
            end else begin
                HRESP = 1'b0; HREADY = ($urandom % 4) != 0; err_pending = 1'b0;
            end
            if (HRESET) err_pending = 1'b0;
            tick();
        end
        HRESET = 1'b0; REQ_VALID = '0;
`ifdef AHBL_ARB_LOCK_EN
        REQ_LOCK = '0;
`endif
        wait_idle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
